// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences a request-driven multiply (clear, run, commit) and
// holds the architectural HI/LO registers with mfhi/mflo/mthi/mtlo access.
module hilo_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    output logic             mult_clr,
    output logic             mult_init,
    input  logic             mult_done,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             terr_q, terr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             init_q, init_d;
    logic             clr_q, clr_d;

    // Next state, operand/product captures, moves, and outputs decoded from the next state
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;

        unique case (state_q)
            StIdle: begin
                if (op_start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    cnt_d   = '0;
                    terr_d  = 1'b0;
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StRun;
            end
            StRun: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A completion seen on the last allowed cycle still wins over the abort
                if (mult_done) begin
                    hi_d    = mult_hi;
                    lo_d    = mult_lo;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    terr_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Moves apply only while not busy; in DONE they override the fresh product
        if (state_q == StIdle || state_q == StDone) begin
            if (mthi) begin
                hi_d = wdata;
            end
            if (mtlo) begin
                lo_d = wdata;
            end
        end

        busy_d = (state_d == StClear) || (state_d == StRun);
        done_d = (state_d == StDone);
        init_d = (state_d == StRun);
        clr_d  = (state_d == StClear);
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            init_q  <= init_d;
            clr_q   <= clr_d;
        end
    end

    // The multiplier is held cleared for as long as reset is low
    assign mult_clr    = clr_q | ~reset;
    assign mult_init   = init_q;
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign rdata       = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed and randomized sequences against a transaction-level
// expectation of latency, HI/LO contents and status flags.
module tb_hilo_ctrl;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 40;
    localparam int          NEVER   = 1000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             op_start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [WIDTH-1:0] mult_a, mult_b;
    logic             mult_clr, mult_init;
    logic             mult_done;
    logic [WIDTH-1:0] mult_hi, mult_lo;
    logic             mthi = 1'b0;
    logic             mtlo = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             rd_sel = 1'b0;
    logic [WIDTH-1:0] rdata;
    logic             busy, done, timeout_err;

    int vectors = 0;
    int miscompares = 0;

    // Expected architectural state
    logic [WIDTH-1:0] ref_hi = '0;
    logic [WIDTH-1:0] ref_lo = '0;
    logic             ref_terr = 1'b0;

    always #5 clk = ~clk;

    hilo_ctrl #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_start   (op_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_clr   (mult_clr),
        .mult_init  (mult_init),
        .mult_done  (mult_done),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wdata      (wdata),
        .rd_sel     (rd_sel),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    // Multiplier stand-in: done becomes visible in RUN cycle m_lat, stays until cleared
    int               m_lat = NEVER;
    int               m_cnt = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_junk = '0;
    logic signed [2*WIDTH-1:0] m_full;

    assign m_full = $signed({{WIDTH{mult_a[WIDTH-1]}}, mult_a})
                  * $signed({{WIDTH{mult_b[WIDTH-1]}}, mult_b});
    assign mult_done = m_done;
    assign mult_hi   = m_done ? m_full[2*WIDTH-1:WIDTH] : m_junk;
    assign mult_lo   = m_done ? m_full[WIDTH-1:0] : ~m_junk;

    always @(posedge clk) begin
        m_junk <= $urandom;
        if (mult_clr) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (mult_init) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat - 1) m_done <= 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*WIDTH-1:0] sprod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag);
        rd_sel = 1'($urandom);
        #1;
        chk(tag, rdata, rd_sel ? ref_hi : ref_lo);
    endtask

    task automatic chk_flags(input string tag, input logic b, input logic d, input logic i,
                             input logic c, input logic t);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_done"}, done, d);
        chk({tag, "_init"}, mult_init, i);
        chk({tag, "_clr"}, mult_clr, c);
        chk({tag, "_terr"}, timeout_err, t);
    endtask

    // Writes attempted while busy must have no effect
    task automatic busy_noise();
        mthi  = 1'($urandom);
        mtlo  = 1'($urandom);
        wdata = $urandom;
    endtask

    task automatic do_reset();
        mthi = 1'b0;
        mtlo = 1'b0;
        op_start = 1'b0;
        reset = 1'b0;
        #1;
        ref_hi = '0;
        ref_lo = '0;
        ref_terr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("rst_mult_a", mult_a, 0);
            chk_rd("rst_rdata");
            cyc();
        end
        reset = 1'b1;
        #1;
        chk_flags("rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called inside an IDLE cycle. Ends in the DONE cycle, the IDLE cycle after a
    // timeout, or the IDLE cycle after a reset aborts it at RUN cycle abort_at.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int lat,
                          input bit hold, input bit wr_hi, input int abort_at);
        logic [2*WIDTH-1:0] p;
        p = sprod(a, b);
        op_start = 1'b1;
        op_a = a;
        op_b = b;
        m_lat = lat;
        mtlo = 1'b0;
        mthi = wr_hi;
        if (wr_hi) begin
            wdata = $urandom;
            ref_hi = wdata;
        end
        cyc();
        mthi = 1'b0;
        op_start = hold;
        op_a = $urandom;
        op_b = $urandom;
        ref_terr = 1'b0;
        chk_flags("clear", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mult_a", mult_a, a);
        chk("mult_b", mult_b, b);
        chk_rd("clear_rdata");
        busy_noise();
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            cyc();
            if (k == abort_at) begin
                do_reset();
                return;
            end
            chk_flags("run", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            chk_rd("run_rdata");
            busy_noise();
            if (k == lat) begin
                cyc();
                mthi = 1'b0;
                mtlo = 1'b0;
                ref_hi = p[2*WIDTH-1:WIDTH];
                ref_lo = p[WIDTH-1:0];
                chk_flags("dn", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                chk_rd("dn_rdata");
                return;
            end
        end
        cyc();
        mthi = 1'b0;
        mtlo = 1'b0;
        ref_terr = 1'b1;
        chk_flags("tmo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_rd("tmo_rdata");
    endtask

    // From a DONE cycle: optional move in that cycle, then step to IDLE and check it
    task automatic leave_done(input bit wr_lo);
        if (wr_lo) begin
            mtlo = 1'b1;
            wdata = $urandom;
            ref_lo = wdata;
        end
        cyc();
        mtlo = 1'b0;
        chk_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0, ref_terr);
        chk_rd("idle_rdata");
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] ra, rb;
        bit wr;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_flags("por", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("por_rdata", rdata, 0);
        reset = 1'b1;
        cyc();
        chk_flags("por_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Normal multiply: done seen in RUN cycle 34
        run_op(32'd7, 32'hFFFF_FFFD, 34, 1'b0, 1'b0, 0);
        leave_done(1'b0);
        rd_sel = 1'b1;
        #1;
        chk("norm_hi", rdata, 32'hFFFF_FFFF);
        rd_sel = 1'b0;
        #1;
        chk("norm_lo", rdata, 32'hFFFF_FFEB);

        // mthi in IDLE
        mthi = 1'b1;
        wdata = 32'hA5A5_A5A5;
        ref_hi = wdata;
        cyc();
        mthi = 1'b0;
        rd_sel = 1'b1;
        #1;
        chk("mthi_idle", rdata, 32'hA5A5_A5A5);

        // Timeout with HI preset to 0x1234
        mthi = 1'b1;
        wdata = 32'h0000_1234;
        ref_hi = wdata;
        cyc();
        mthi = 1'b0;
        run_op($urandom, $urandom, NEVER, 1'b0, 1'b0, 0);
        rd_sel = 1'b1;
        #1;
        chk("tmo_hi", rdata, 32'h0000_1234);

        // Next op clears timeout_err; mtlo in DONE overrides product
        run_op($urandom, $urandom, 12, 1'b0, 1'b0, 0);
        leave_done(1'b1);

        // Completion on the final allowed cycle beats the abort; one cycle later times out
        run_op($urandom, $urandom, int'(TIMEOUT), 1'b0, 1'b0, 0);
        leave_done(1'b0);
        run_op($urandom, $urandom, int'(TIMEOUT) + 1, 1'b0, 1'b0, 0);

        // Reset at RUN cycle 10, then a full sequence
        run_op($urandom, $urandom, 30, 1'b0, 1'b0, 10);
        run_op($urandom, $urandom, 20, 1'b0, 1'b0, 0);
        leave_done(1'b0);

        // Back-to-back with op_start held; stale done left high by the multiplier
        run_op($urandom, $urandom, 5, 1'b1, 1'b0, 0);
        leave_done(1'b0);
        run_op($urandom, $urandom, 3, 1'b0, 1'b1, 0);
        leave_done(1'b0);

        // Minimum latency
        run_op($urandom, $urandom, 2, 1'b0, 1'b0, 0);
        leave_done(1'b0);

        // Randomized operations
        for (int n = 0; n < 16; n++) begin
            lat = $urandom_range(2, int'(TIMEOUT) + 4);
            ra = $urandom;
            rb = $urandom;
            wr = 1'($urandom);
            run_op(ra, rb, lat, 1'b0, wr, 0);
            if (lat <= int'(TIMEOUT)) leave_done(1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
